// File: rtl/enc_16to4_queued.sv
// Queued 16-to-4 priority encoder: captures decoded request lines into a sticky
// pending set and offers them one index at a time, lowest first, over valid/ready.
module enc_16to4_queued #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [0:IN_W-1]  req,
  output logic [OUT_W-1:0] encoded,
  output logic             valid,
  input  logic             ready,
  output logic [0:IN_W-1]  pending,
  output logic             overrun
);

  localparam logic StIdle  = 1'b0;
  localparam logic StOffer = 1'b1;

  logic             state_q, state_d;
  logic [OUT_W-1:0] encoded_q, encoded_d;
  logic [0:IN_W-1]  pending_q, pending_d;
  logic             overrun_q, overrun_d;

  logic [0:IN_W-1]  cap;
  logic [0:IN_W-1]  src;
  logic [0:IN_W-1]  take;
  logic [OUT_W-1:0] sel;
  logic             any;

  // Lowest set index of pending plus this cycle's capture.
  always_comb begin
    cap = En ? req : '0;
    src = pending_q | cap;
    any = |src;
    sel = '0;
    for (int i = int'(IN_W) - 1; i >= 0; i--) begin
      if (src[i]) sel = OUT_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    encoded_d = encoded_q;
    take      = '0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          encoded_d = sel;
          take[sel] = 1'b1;
          state_d   = StOffer;
        end
      end
      StOffer: begin
        if (ready) begin
          if (any) begin
            encoded_d = sel;
            take[sel] = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A taken bit survives only if it was already pending and a fresh request lands on it.
  always_comb begin
    pending_d = (take & pending_q & cap) | (~take & (pending_q | cap));
    overrun_d = overrun_q | (|(cap & pending_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      encoded_q <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      encoded_q <= encoded_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign encoded = encoded_q;
  assign valid   = (state_q == StOffer);
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_enc_16to4_queued.sv
// Scoreboard bench for enc_16to4_queued: a count-based reference model predicts each
// offered index; a negedge monitor pops the expectation on every handshake.
module tb_enc_16to4_queued;

  logic        clk;
  logic        rst_n;
  logic        En;
  logic [0:15] req;
  logic [3:0]  encoded;
  logic        valid;
  logic        ready;
  logic [0:15] pending;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  bit m_pend[16];
  bit m_ovr;
  bit m_val;
  int m_enc;
  int exp_q[$];

  enc_16to4_queued dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .En      (En),
    .req     (req),
    .encoded (encoded),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:15] oh(input int idx);
    logic [0:15] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each index holds a request count; serving an index removes one entry.
  task automatic model_edge(input logic en_i, input logic [0:15] r, input logic rdy,
                            input logic rst);
    int cnt[16];
    int s;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      m_ovr = 1'b0;
      m_val = 1'b0;
      m_enc = 0;
      exp_q.delete();
      return;
    end
    s = -1;
    for (int i = 0; i < 16; i++) begin
      cnt[i] = int'(m_pend[i]) + ((en_i && r[i]) ? 1 : 0);
      if (cnt[i] == 2) m_ovr = 1'b1;
    end
    for (int i = 0; i < 16; i++) if (s < 0 && cnt[i] > 0) s = i;
    if (!m_val || rdy) begin
      if (s >= 0) begin
        cnt[s]--;
        m_val = 1'b1;
        m_enc = s;
        exp_q.push_back(s);
      end else begin
        m_val = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++) m_pend[i] = (cnt[i] > 0);
  endtask

  task automatic step(input logic en_i, input logic [0:15] r, input logic rdy,
                      input logic rst);
    logic [0:15] mp;
    En    = en_i;
    req   = r;
    ready = rdy;
    rst_n = rst;
    model_edge(en_i, r, rdy, rst);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) mp[i] = m_pend[i];
    check("valid", int'(valid), int'(m_val));
    check("pending", int'(pending), int'(mp));
    check("overrun", int'(overrun), int'(m_ovr));
    check("encoded", int'(encoded), m_enc);
  endtask

  // Monitor: every handshake must match the oldest predicted offer.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got index %0d expected none at %0t", encoded, $time);
        end else begin
          e = exp_q.pop_front();
          if (int'(encoded) != e) begin
            errors++;
            $display("FAIL sb_index: got %0d expected %0d at %0t", encoded, e, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [0:15] r;
    rst_n = 1'b0;
    En    = 1'b0;
    req   = '0;
    ready = 1'b0;

    // Reset and idle
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, '0, 1'b1, 1'b1);
    check("t1_valid", int'(valid), 0);
    check("t1_encoded", int'(encoded), 0);

    // Single pulse, one-cycle latency
    step(1'b1, oh(5), 1'b1, 1'b1);
    check("t2_valid", int'(valid), 1);
    check("t2_encoded", int'(encoded), 5);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t2_idle", int'(valid), 0);
    check("t2_pending", int'(pending), 0);

    // Three simultaneous requests, back-to-back
    r = oh(3) | oh(9) | oh(14);
    step(1'b1, r, 1'b1, 1'b1);
    check("t3_enc0", int'(encoded), 3);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t3_enc1", int'(encoded), 9);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t3_enc2", int'(encoded), 14);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t3_idle", int'(valid), 0);

    // Stall holds the offer while pending accumulates
    step(1'b1, oh(2), 1'b0, 1'b1);
    step(1'b1, oh(1), 1'b0, 1'b1);
    check("t4_hold", int'(encoded), 2);
    check("t4_pending", int'(pending), int'(oh(1)));
    step(1'b1, '0, 1'b0, 1'b1);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t4_next", int'(encoded), 1);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t4_idle", int'(valid), 0);

    // Overrun on repeated request for a pending index
    step(1'b1, oh(0), 1'b0, 1'b1);
    step(1'b1, oh(7), 1'b0, 1'b1);
    check("t5_no_ovr", int'(overrun), 0);
    step(1'b1, oh(7), 1'b0, 1'b1);
    check("t5_ovr", int'(overrun), 1);
    step(1'b1, oh(7), 1'b0, 1'b1);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t5_enc7", int'(encoded), 7);
    step(1'b1, '0, 1'b1, 1'b1);
    check("t5_once", int'(valid), 0);
    check("t5_sticky", int'(overrun), 1);

    // Full pending set, reset wins, then disabled capture
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    check("t6_full", int'(pending), 16'hFFFF);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    check("t6_rst_valid", int'(valid), 0);
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_ovr", int'(overrun), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'hFFFF, 1'b1, 1'b1);
    check("t6_en_off", int'(valid), 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      r = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) r = 16'($urandom);
      step(1'($urandom_range(0, 4) != 0), r, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 299) != 0));
    end

    // Drain everything left
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
